// File: rtl/mat_mul_pkg.sv
// Shared state encoding, counter width and accumulator sizing for mat_mul_stream.
package mat_mul_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Accumulator wide enough that an inner product of inner_len terms never overflows.
    function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned inner_len);
        return 2 * data_w + $clog2(inner_len) + 1;
    endfunction

endpackage

// File: rtl/mat_mul_mac.sv
// Signed multiply-accumulate with synchronous clear/enable; exposes the next accumulator value.
module mat_mul_mac #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 67
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [ACC_WIDTH-1:0]  o_acc_nxt_c
);

    logic [2*DATA_WIDTH-1:0] w_a_ext;
    logic [2*DATA_WIDTH-1:0] w_b_ext;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]    w_prod_ext;
    logic [ACC_WIDTH-1:0]    r_acc;

    // Sign-extend operands so the low 2*DATA_WIDTH bits of the product are the exact signed result.
    assign w_a_ext     = {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a};
    assign w_b_ext     = {{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b};
    assign w_prod      = w_a_ext * w_b_ext;
    assign w_prod_ext  = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
    assign o_acc_nxt_c = r_acc + w_prod_ext;

    always_ff @(posedge clk) begin
        if (!rstn || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_acc_nxt_c;
        end
    end

endmodule

// File: rtl/mat_mul_stream.sv
// Streaming signed matrix multiplier C = A x B with one MAC datapath and a busy-cycle counter.
// Define MAT_MUL_SATURATE_EN to clamp results to DATA_WIDTH instead of truncating.
module mat_mul_stream
    import mat_mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROWS_A     = 4,
    parameter int unsigned COLS_A     = 4,
    parameter int unsigned COLS_B     = 4,
    parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, COLS_A)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [CNT_W-1:0]      counter
);

    localparam int unsigned NA      = ROWS_A * COLS_A;
    localparam int unsigned NB      = COLS_A * COLS_B;
    localparam int unsigned NW      = NA + NB;
    localparam int unsigned A_IDX_W = (NA > 1) ? $clog2(NA) : 1;
    localparam int unsigned B_IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned W_CNT_W = $clog2(NW);
    localparam int unsigned I_W     = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
    localparam int unsigned J_W     = (COLS_B > 1) ? $clog2(COLS_B) : 1;
    localparam int unsigned K_W     = (COLS_A > 1) ? $clog2(COLS_A) : 1;

`ifdef MAT_MUL_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

    state_t                r_state, w_state_nxt;
    logic [W_CNT_W-1:0]    r_wcnt, w_wcnt_nxt;
    logic [I_W-1:0]        r_i, w_i_nxt;
    logic [J_W-1:0]        r_j, w_j_nxt;
    logic [K_W-1:0]        r_k, w_k_nxt;
    logic                  r_in_ready, w_in_ready_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic                  r_out_last, w_out_last_nxt;
    logic [DATA_WIDTH-1:0] r_out_data, w_out_data_nxt;
    logic [CNT_W-1:0]      r_counter, w_counter_nxt;

    logic                  w_in_fire, w_out_fire;
    logic                  w_last_word, w_is_a;
    logic                  w_i_last, w_j_last, w_k_last;
    logic                  w_acc_clr, w_acc_en;
    logic [A_IDX_W-1:0]    w_a_waddr, w_a_raddr;
    logic [B_IDX_W-1:0]    w_b_waddr, w_b_raddr;
    logic [ACC_WIDTH-1:0]  w_acc_nxt;

    logic [DATA_WIDTH-1:0] r_a [NA];
    logic [DATA_WIDTH-1:0] r_b [NB];

    function automatic logic [DATA_WIDTH-1:0] to_out(input logic [ACC_WIDTH-1:0] acc);
        logic [DATA_WIDTH-1:0] res;
        res = acc[DATA_WIDTH-1:0];
`ifdef MAT_MUL_SATURATE_EN
        if ($signed(acc) > $signed(SAT_MAX)) begin
            res = SAT_MAX[DATA_WIDTH-1:0];
        end else if ($signed(acc) < $signed(SAT_MIN)) begin
            res = SAT_MIN[DATA_WIDTH-1:0];
        end
`endif
        return res;
    endfunction

    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = r_out_valid & out_ready;
    assign w_last_word = (r_wcnt == W_CNT_W'(NW - 1));
    assign w_is_a      = (r_wcnt < W_CNT_W'(NA));
    assign w_i_last    = (r_i == I_W'(ROWS_A - 1));
    assign w_j_last    = (r_j == J_W'(COLS_B - 1));
    assign w_k_last    = (r_k == K_W'(COLS_A - 1));
    assign w_a_waddr   = A_IDX_W'(r_wcnt);
    assign w_b_waddr   = B_IDX_W'(r_wcnt - W_CNT_W'(NA));
    assign w_a_raddr   = A_IDX_W'(r_i * COLS_A + r_k);
    assign w_b_raddr   = B_IDX_W'(r_k * COLS_B + r_j);

    mat_mul_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk         (clk),
        .rstn        (rstn),
        .i_clr       (w_acc_clr),
        .i_en        (w_acc_en),
        .i_a         (r_a[w_a_raddr]),
        .i_b         (r_b[w_b_raddr]),
        .o_acc_nxt_c (w_acc_nxt)
    );

    // Operand storage: A words first, then B words, both row-major.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            if (w_is_a) begin
                r_a[w_a_waddr] <= in_data;
            end else begin
                r_b[w_b_waddr] <= in_data;
            end
        end
    end

    // Next-state, index, output and counter logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_wcnt_nxt     = r_wcnt;
        w_i_nxt        = r_i;
        w_j_nxt        = r_j;
        w_k_nxt        = r_k;
        w_acc_clr      = 1'b0;
        w_acc_en       = 1'b0;
        w_out_data_nxt = r_out_data;
        w_counter_nxt  = r_counter;

        case (r_state)
            LOAD: begin
                if (w_in_fire) begin
                    if (r_wcnt == '0) begin
                        w_counter_nxt = '0;
                    end
                    if (w_last_word) begin
                        w_wcnt_nxt  = '0;
                        w_i_nxt     = '0;
                        w_j_nxt     = '0;
                        w_k_nxt     = '0;
                        w_acc_clr   = 1'b1;
                        w_state_nxt = MAC;
                    end else begin
                        w_wcnt_nxt = r_wcnt + W_CNT_W'(1);
                    end
                end
            end
            MAC: begin
                w_acc_en = 1'b1;
                if (w_k_last) begin
                    w_k_nxt        = '0;
                    w_out_data_nxt = to_out(w_acc_nxt);
                    w_state_nxt    = OUT;
                end else begin
                    w_k_nxt = r_k + K_W'(1);
                end
            end
            OUT: begin
                if (w_out_fire) begin
                    if (w_i_last && w_j_last) begin
                        w_i_nxt     = '0;
                        w_j_nxt     = '0;
                        w_state_nxt = LOAD;
                    end else begin
                        if (w_j_last) begin
                            w_j_nxt = '0;
                            w_i_nxt = r_i + I_W'(1);
                        end else begin
                            w_j_nxt = r_j + J_W'(1);
                        end
                        w_acc_clr   = 1'b1;
                        w_state_nxt = MAC;
                    end
                end
            end
            default: w_state_nxt = LOAD;
        endcase

        // Busy cycles are every MAC/OUT cycle, saturating at all-ones.
        if (r_state != LOAD && r_counter != '1) begin
            w_counter_nxt = r_counter + CNT_W'(1);
        end

        w_in_ready_nxt  = (w_state_nxt == LOAD);
        w_out_valid_nxt = (w_state_nxt == OUT);
        w_out_last_nxt  = (w_state_nxt == OUT) && (w_i_nxt == I_W'(ROWS_A - 1))
                          && (w_j_nxt == J_W'(COLS_B - 1));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= LOAD;
            r_wcnt      <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_counter   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_i         <= w_i_nxt;
            r_j         <= w_j_nxt;
            r_k         <= w_k_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_data  <= w_out_data_nxt;
            r_counter   <= w_counter_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign counter   = r_counter;

endmodule

// File: tb/tb_mat_mul_stream.sv
// Directed self-checking bench for mat_mul_stream (8-bit elements, 4x4 by 4x4).
module tb_mat_mul_stream;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [31:0] counter;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_a   [16];
    logic [7:0] m_b   [16];
    logic [7:0] m_exp [16];

    always #5 clk = ~clk;

    mat_mul_stream #(
        .DATA_WIDTH (8),
        .ROWS_A     (4),
        .COLS_A     (4),
        .COLS_B     (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .counter   (counter)
    );

    // Streams A then B; reports how many cycles the load took.
    task automatic load_job(output int cycles);
        int  n;
        int  guard;
        logic acc;
        n = 0;
        guard = 0;
        while (n < 32 && guard < 500) begin
            in_valid = 1'b1;
            in_data  = (n < 16) ? m_a[n] : m_b[n-16];
            acc      = in_ready;
            @(negedge clk);
            guard++;
            if (acc) begin
                n++;
                if (n == 1) begin
                    checks++;
                    if (counter !== 32'd0) begin
                        errors++;
                        $display("FAIL counter_clear_first_word got %0d want 0", counter);
                    end
                end
            end
        end
        in_valid = 1'b0;
        cycles = guard;
        if (n < 32) begin
            checks++;
            errors++;
            $display("FAIL load_timeout accepted %0d want 32", n);
        end
    endtask

    // Drains all 16 results, optionally stalling one element and injecting junk on the input.
    task automatic run_outputs(input int stall_elem, input int stall_cycles, input logic junk,
                               input int exp_counter);
        int n, guard, stalls, first;
        logic [7:0] held;
        n = 0; guard = 0; stalls = 0; first = -1; held = '0;
        out_ready = 1'b1;
        while (n < 16 && guard < 1000) begin
            in_valid = junk;
            if (junk) in_data = 8'($urandom);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_busy elem %0d got %b want 0", n, in_ready);
            end
            if (out_valid === 1'b1) begin
                if (first < 0) begin
                    first = guard;
                    checks++;
                    if (first != 4) begin
                        errors++;
                        $display("FAIL first_latency got %0d want 4", first);
                    end
                end
                if (n == stall_elem && stalls < stall_cycles) begin
                    out_ready = 1'b0;
                    if (stalls > 0) begin
                        checks++;
                        if (out_data !== held) begin
                            errors++;
                            $display("FAIL stall_stable got %h want %h", out_data, held);
                        end
                    end
                    held = out_data;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    checks++;
                    if (out_data !== m_exp[n]) begin
                        errors++;
                        $display("FAIL out_data elem %0d got %h want %h", n, out_data, m_exp[n]);
                    end
                    checks++;
                    if (out_last !== 1'(n == 15)) begin
                        errors++;
                        $display("FAIL out_last elem %0d got %b want %b", n, out_last, n == 15);
                    end
                    n++;
                    if (n == 16) in_valid = 1'b0;
                end
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (n < 16) begin
            checks++;
            errors++;
            $display("FAIL output_timeout got %0d elems want 16", n);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL job_end got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
        checks++;
        if (counter !== 32'(exp_counter)) begin
            errors++;
            $display("FAIL job_counter got %0d want %0d", counter, exp_counter);
        end
    endtask

    task automatic fill_identity();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                m_a[r*4+c]   = (r == c) ? 8'd1 : 8'd0;
                m_b[r*4+c]   = 8'(r*4 + c);
                m_exp[r*4+c] = 8'(r*4 + c);
            end
        end
    endtask

    task automatic fill_const(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ev);
        for (int n = 0; n < 16; n++) begin
            m_a[n] = av; m_b[n] = bv; m_exp[n] = ev;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h want 00", out_data); end
        checks++;
        if (counter !== 32'd0) begin errors++; $display("FAIL rst_counter got %0d want 0", counter); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int cyc;
        fill_identity();
        load_job(cyc);
        run_outputs(-1, 0, 1'b0, 80);
        repeat (3) @(negedge clk);
        checks++;
        if (counter !== 32'd80) begin errors++; $display("FAIL counter_hold got %0d want 80", counter); end
    endtask

    task automatic test_signed();
        int cyc;
        for (int n = 0; n < 16; n++) begin
            m_a[n]   = 8'(n);
            m_b[n]   = (n % 5 == 0) ? 8'hFF : 8'h00;
            m_exp[n] = 8'(-n);
        end
        load_job(cyc);
        run_outputs(-1, 0, 1'b0, 80);
    endtask

    task automatic test_backpressure();
        int cyc;
        fill_identity();
        load_job(cyc);
        run_outputs(0, 3, 1'b0, 83);
    endtask

    task automatic test_input_gating();
        int cyc;
        fill_const(8'd2, 8'd3, 8'd24);
        load_job(cyc);
        run_outputs(-1, 0, 1'b1, 80);
    endtask

    task automatic test_back_to_back();
        int cyc;
        fill_identity();
        load_job(cyc);
        checks++;
        if (cyc != 32) begin errors++; $display("FAIL b2b_load_cycles got %0d want 32", cyc); end
        run_outputs(-1, 0, 1'b0, 80);
    endtask

    task automatic test_saturation();
        int cyc;
`ifdef MAT_MUL_SATURATE_EN
        fill_const(8'd127, 8'd127, 8'h7F);
`else
        fill_const(8'd127, 8'd127, 8'h04);
`endif
        load_job(cyc);
        run_outputs(-1, 0, 1'b0, 80);
`ifdef MAT_MUL_SATURATE_EN
        fill_const(8'h80, 8'd127, 8'h80);
`else
        fill_const(8'h80, 8'd127, 8'h00);
`endif
        load_job(cyc);
        run_outputs(-1, 0, 1'b0, 80);
    endtask

    task automatic test_reset_mid_job();
        int cyc, hs, guard, leaked;
        fill_identity();
        load_job(cyc);
        out_ready = 1'b1;
        hs = 0; guard = 0;
        while (hs < 5 && guard < 200) begin
            if (out_valid === 1'b1) hs++;
            @(negedge clk);
            guard++;
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || counter !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got valid=%b ready=%b cnt=%0d want 0 1 0",
                     out_valid, in_ready, counter);
        end
        leaked = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) leaked++;
        end
        checks++;
        if (leaked != 0) begin errors++; $display("FAIL mid_reset_leak got %0d want 0", leaked); end
        fill_identity();
        load_job(cyc);
        run_outputs(-1, 0, 1'b0, 80);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_backpressure();
        test_input_gating();
        test_back_to_back();
        test_saturation();
        test_reset_mid_job();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
